// File: rtl/sa_oport.sv
// -----------------------------------------------------------------------------
// sa_oport -- output-port stage of the two-stage switch allocator.
//
// One instance sits on each router output port. Each input port presents at
// most one request, already chosen by that input's own VC arbitration. This
// stage grants one input per cycle with round-robin fairness. Once a head flit
// wins, the output stays locked to that input until its tail flit is granted.
// Every grant also needs a downstream credit. The crossbar select is registered
// here for the switch-traversal stage.
//
// Ports
//   clk            in   1   clock, all state on the rising edge
//   rst            in   1   synchronous reset, active-high
//   reqSAIn        in   N   bit i: input port i requests this output
//   tailIn         in   N   bit i: input i's candidate flit is a tail
//   creditIn       in   1   downstream freed one buffer slot
//   outputGrantSA  out  N   one-hot/zero grant, same cycle as the request
//   xbarSelect     out  N   registered grant, drives the crossbar column
//   xbarValid      out  1   registered |grant, flit valid on this output
//   creditCount    out  CW  current downstream credits
//   creditErr      out  1   sticky: credit returned while already full
// -----------------------------------------------------------------------------
module sa_oport #(
    parameter int N        = 5,
    parameter int CRED_MAX = 4,
    localparam int CW      = $clog2(CRED_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  reqSAIn,
    input  logic [N-1:0]  tailIn,
    input  logic          creditIn,
    output logic [N-1:0]  outputGrantSA,
    output logic [N-1:0]  xbarSelect,
    output logic          xbarValid,
    output logic [CW-1:0] creditCount,
    output logic          creditErr
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          credit_err_q, credit_err_d;
    logic [N-1:0]  xbar_select_q, xbar_select_d;
    logic          xbar_valid_q, xbar_valid_d;

    logic [N-1:0]  grant;
    logic          transfer;
    logic          win_found;
    logic [PW-1:0] win_idx;

    // Index after i, wrapping N-1 back to 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // Round-robin winner: first set request at or above rr_ptr_q, wrapping.
    // The loop runs from the farthest candidate to the nearest so the nearest
    // one is written last and takes priority.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int s;
            s = int'(rr_ptr_q) + k;
            if (s >= N) s = s - N;
            if (reqSAIn[PW'(s)]) begin
                win_found = 1'b1;
                win_idx   = PW'(s);
            end
        end
    end

    // Grant, next state, credit bookkeeping and crossbar registers.
    always_comb begin
        grant         = '0;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        credit_d      = credit_q;
        credit_err_d  = credit_err_q;

        // With no credit left there is no grant, whichever state we are in.
        if (!rst && credit_q != '0) begin
            if (state_q == S_IDLE) begin
                if (win_found) grant[win_idx] = 1'b1;
            end else begin
                // While locked, only the owner can win. If it stops
                // requesting, the cycle is a bubble and the lock holds.
                if (reqSAIn[owner_q]) grant[owner_q] = 1'b1;
            end
        end
        transfer = |grant;

        if (transfer) begin
            if (state_q == S_IDLE) begin
                if (tailIn[win_idx]) begin
                    rr_ptr_d = next_idx(win_idx);
                end else begin
                    state_d = S_LOCKED;
                    owner_d = win_idx;
                end
            end else if (tailIn[owner_q]) begin
                state_d  = S_IDLE;
                rr_ptr_d = next_idx(owner_q);
            end
        end

        // A grant and a returned credit in the same cycle cancel out.
        // A credit returned when the counter is already full is an
        // upstream protocol error. The counter stays saturated and the
        // error flag is set.
        unique case ({transfer, creditIn})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CW'(CRED_MAX)) credit_err_d = 1'b1;
                else                           credit_d     = credit_q + 1'b1;
            end
            default: ;
        endcase

        xbar_select_d = grant;
        xbar_valid_d  = transfer;
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before the edge, whatever order they are listed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            credit_q      <= CW'(CRED_MAX);
            credit_err_q  <= 1'b0;
            xbar_select_q <= '0;
            xbar_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            credit_q      <= credit_d;
            credit_err_q  <= credit_err_d;
            xbar_select_q <= xbar_select_d;
            xbar_valid_q  <= xbar_valid_d;
        end
    end

    assign outputGrantSA = grant;
    assign xbarSelect    = xbar_select_q;
    assign xbarValid     = xbar_valid_q;
    assign creditCount   = credit_q;
    assign creditErr     = credit_err_q;

endmodule

// File: tb/tb_sa_oport.sv
// -----------------------------------------------------------------------------
// tb_sa_oport -- directed testbench for sa_oport (N=5, CRED_MAX=4).
// Inputs change on the falling edge. The combinational grant is sampled 1ns
// later, and the registered outputs are sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sa_oport;

    localparam int N  = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  reqSAIn;
    logic [N-1:0]  tailIn;
    logic          creditIn;
    logic [N-1:0]  outputGrantSA;
    logic [N-1:0]  xbarSelect;
    logic          xbarValid;
    logic [CW-1:0] creditCount;
    logic          creditErr;

    int checks = 0;
    int errors = 0;

    sa_oport #(.N(N), .CRED_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .reqSAIn       (reqSAIn),
        .tailIn        (tailIn),
        .creditIn      (creditIn),
        .outputGrantSA (outputGrantSA),
        .xbarSelect    (xbarSelect),
        .xbarValid     (xbarValid),
        .creditCount   (creditCount),
        .creditErr     (creditErr)
    );

    always #5 clk = ~clk;

    // Apply inputs on the falling edge, then let the combinational logic settle.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] tail,
                         input logic cred);
        @(negedge clk);
        reqSAIn  = req;
        tailIn   = tail;
        creditIn = cred;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    // Reset with every input requesting, to show the grant is forced to 0.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; reqSAIn = '1; tailIn = '1; creditIn = 1'b0;
        #1;
        checks++;
        if (outputGrantSA !== 5'b00000) begin
            errors++; $display("FAIL reset_grant got %b exp %b", outputGrantSA, 5'b00000);
        end
        clock_edge();
        drive('0, '0, 1'b0);
        rst = 1'b0;
        checks++;
        if (xbarSelect !== 5'b00000 || xbarValid !== 1'b0 || creditCount !== 3'd4 || creditErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got sel=%b v=%b cc=%0d err=%b exp sel=00000 v=0 cc=4 err=0",
                     xbarSelect, xbarValid, creditCount, creditErr);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [3];
        exp_g = '{5'b00010, 5'b00100, 5'b10000};
        test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'b10110, 5'b11111, 1'b0);
            checks++;
            if (outputGrantSA !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant%0d got %b exp %b", i, outputGrantSA, exp_g[i]);
            end
            clock_edge();
            checks++;
            if (xbarSelect !== exp_g[i] || xbarValid !== 1'b1) begin
                errors++; $display("FAIL rr_xbar%0d got %b/%b exp %b/1", i, xbarSelect, xbarValid, exp_g[i]);
            end
        end
        checks++;
        if (creditCount !== 3'd1) begin
            errors++; $display("FAIL rr_credit got %0d exp 1", creditCount);
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] tails [4];
        logic [N-1:0] exp_g [4];
        tails = '{5'b00000, 5'b00000, 5'b00010, 5'b01000};
        exp_g = '{5'b00010, 5'b00010, 5'b00010, 5'b01000};
        test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(5'b01010, tails[i], 1'b0);
            checks++;
            if (outputGrantSA !== exp_g[i]) begin
                errors++; $display("FAIL lock_grant%0d got %b exp %b", i, outputGrantSA, exp_g[i]);
            end
            clock_edge();
        end
        checks++;
        if (creditCount !== 3'd0) begin
            errors++; $display("FAIL lock_credit got %0d exp 0", creditCount);
        end
    endtask

    task automatic test_bubble();
        test_reset();
        drive(5'b00100, 5'b00000, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b00100) begin
            errors++; $display("FAIL bub_head got %b exp 00100", outputGrantSA);
        end
        clock_edge();
        for (int i = 0; i < 2; i++) begin
            drive(5'b11011, 5'b11111, 1'b0);
            checks++;
            if (outputGrantSA !== 5'b00000) begin
                errors++; $display("FAIL bub_gap%0d got %b exp 00000", i, outputGrantSA);
            end
            clock_edge();
        end
        checks++;
        if (xbarValid !== 1'b0 || creditCount !== 3'd3) begin
            errors++; $display("FAIL bub_regs got v=%b cc=%0d exp v=0 cc=3", xbarValid, creditCount);
        end
        drive(5'b11111, 5'b00100, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b00100) begin
            errors++; $display("FAIL bub_tail got %b exp 00100", outputGrantSA);
        end
        clock_edge();
        // The lock is released and the pointer moves to 3.
        drive(5'b11011, 5'b11111, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b01000) begin
            errors++; $display("FAIL bub_after got %b exp 01000", outputGrantSA);
        end
        clock_edge();
    endtask

    task automatic test_credit_exhaust();
        logic [CW-1:0] exp_cc [4];
        exp_cc = '{3'd3, 3'd2, 3'd1, 3'd0};
        test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(5'b00001, 5'b11111, 1'b0);
            checks++;
            if (outputGrantSA !== 5'b00001) begin
                errors++; $display("FAIL cr_grant%0d got %b exp 00001", i, outputGrantSA);
            end
            clock_edge();
            checks++;
            if (creditCount !== exp_cc[i]) begin
                errors++; $display("FAIL cr_count%0d got %0d exp %0d", i, creditCount, exp_cc[i]);
            end
        end
        drive(5'b00001, 5'b11111, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b00000) begin
            errors++; $display("FAIL cr_zero got %b exp 00000", outputGrantSA);
        end
        clock_edge();
        // The credit arrives while the counter is 0, so it is granted only next cycle.
        drive(5'b00001, 5'b11111, 1'b1);
        checks++;
        if (outputGrantSA !== 5'b00000) begin
            errors++; $display("FAIL cr_ret_same got %b exp 00000", outputGrantSA);
        end
        clock_edge();
        checks++;
        if (creditCount !== 3'd1) begin
            errors++; $display("FAIL cr_ret_count got %0d exp 1", creditCount);
        end
        drive(5'b00001, 5'b11111, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b00001) begin
            errors++; $display("FAIL cr_one_more got %b exp 00001", outputGrantSA);
        end
        clock_edge();
        drive(5'b00001, 5'b11111, 1'b0);
        checks++;
        if (outputGrantSA !== 5'b00000 || creditCount !== 3'd0) begin
            errors++; $display("FAIL cr_exhaust2 got %b cc=%0d exp 00000 cc=0", outputGrantSA, creditCount);
        end
        clock_edge();
    endtask

    task automatic test_credit_edges();
        test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(5'b00001, 5'b11111, 1'b0);
            clock_edge();
        end
        drive(5'b00001, 5'b11111, 1'b1);
        checks++;
        if (outputGrantSA !== 5'b00001) begin
            errors++; $display("FAIL ce_grant got %b exp 00001", outputGrantSA);
        end
        clock_edge();
        checks++;
        if (creditCount !== 3'd2) begin
            errors++; $display("FAIL ce_coincident got %0d exp 2", creditCount);
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'b00000, 5'b00000, 1'b1);
            clock_edge();
        end
        checks++;
        if (creditCount !== 3'd4 || creditErr !== 1'b0) begin
            errors++; $display("FAIL ce_refill got cc=%0d err=%b exp cc=4 err=0", creditCount, creditErr);
        end
        drive(5'b00000, 5'b00000, 1'b1);
        clock_edge();
        checks++;
        if (creditCount !== 3'd4 || creditErr !== 1'b1) begin
            errors++; $display("FAIL ce_overflow got cc=%0d err=%b exp cc=4 err=1", creditCount, creditErr);
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'b00001, 5'b11111, 1'b0);
            clock_edge();
        end
        checks++;
        if (creditErr !== 1'b1) begin
            errors++; $display("FAIL ce_sticky got %b exp 1", creditErr);
        end
    endtask

    task automatic test_reset_in_lock();
        test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(5'b00100, 5'b00000, 1'b0);
            clock_edge();
        end
        checks++;
        if (creditCount !== 3'd2 || xbarValid !== 1'b1) begin
            errors++; $display("FAIL rl_pre got cc=%0d v=%b exp cc=2 v=1", creditCount, xbarValid);
        end
        @(negedge clk);
        rst = 1'b1; reqSAIn = 5'b11111; tailIn = 5'b00000;
        #1;
        checks++;
        if (outputGrantSA !== 5'b00000) begin
            errors++; $display("FAIL rl_grant got %b exp 00000", outputGrantSA);
        end
        clock_edge();
        checks++;
        if (xbarValid !== 1'b0 || xbarSelect !== 5'b00000 || creditCount !== 3'd4) begin
            errors++; $display("FAIL rl_regs got v=%b sel=%b cc=%0d exp v=0 sel=00000 cc=4",
                               xbarValid, xbarSelect, creditCount);
        end
        // After reset the block is IDLE with the pointer at 0, so input 0 wins.
        drive(5'b11111, 5'b11111, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (outputGrantSA !== 5'b00001) begin
            errors++; $display("FAIL rl_after got %b exp 00001", outputGrantSA);
        end
        clock_edge();
    endtask

    initial begin
        rst = 1'b1; reqSAIn = '0; tailIn = '0; creditIn = 1'b0;
        test_round_robin();
        test_lock();
        test_bubble();
        test_credit_exhaust();
        test_credit_edges();
        test_reset_in_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
